// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the dual-port ROM pair streamer.
// The beat layout depends on DATA_WIDTH and is declared in the top level.
package rom_stream_pkg;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PIPE_LAT   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // Sideband that travels alongside an issued address pair until its data returns.
  typedef struct packed {
    logic valid;
    logic keep_hi;
    logic last;
  } tag_t;

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO with occupancy count; output reads as zero when empty.
// Depth must be a power of two.
module rom_stream_fifo
  import rom_stream_pkg::*;
#(
  parameter int unsigned Width = 26,
  parameter int unsigned Depth = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             pop_en;

  always_comb begin
    pop_en  = pop_i & (count_q != '0);
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{PtrW{1'b0}}, push_i} - {{PtrW{1'b0}}, pop_en};
    end
  end

endmodule

// File: rtl/rom_pair_streamer.sv
// Drives a dual-port 1-cycle-latency ROM two words at a time and streams the
// returned word pairs out as valid/ready beats with keep/last sideband.
module rom_pair_streamer
  import rom_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [LEN_WIDTH-1:0]  word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_a_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_b_o,
  input  logic [DATA_WIDTH-1:0] rom_q_a_i,
  input  logic [DATA_WIDTH-1:0] rom_q_b_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_lo_o,
  output logic [DATA_WIDTH-1:0] m_data_hi_o,
  output logic                  m_keep_hi_o,
  output logic                  m_last_o
);

  typedef struct packed {
    logic                  last;
    logic                  keep_hi;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
  } beat_t;

  localparam int unsigned          CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(1) << ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] Two    = LEN_WIDTH'(2);

  state_e                       state_q;
  logic [ADDR_WIDTH-1:0]        ptr_q, rom_addr_a_q, rom_addr_b_q;
  logic [LEN_WIDTH-1:0]         remaining_q, rem_next, req_len;
  logic                         busy_q, done_q;
  tag_t [PIPE_LAT-1:0]          tag_q;
  logic [CntW-1:0]              fifo_count, inflight, credit;
  logic                         fifo_empty, pop, issue;
  beat_t                        push_beat, head_beat;

  always_comb begin
    pop      = ~fifo_empty & m_ready_i;
    inflight = CntW'(tag_q[0].valid) + CntW'(tag_q[1].valid);
    // Occupancy the FIFO could reach once every in-flight pair has landed.
    credit   = fifo_count + inflight - CntW'(pop);
    issue    = (state_q == StRun) && (remaining_q != '0) && (credit < CntW'(FIFO_DEPTH));
    rem_next = (remaining_q >= Two) ? remaining_q - Two : '0;
    req_len  = (word_count_i > MaxLen) ? MaxLen : word_count_i;

    push_beat.last    = tag_q[1].last;
    push_beat.keep_hi = tag_q[1].keep_hi;
    push_beat.hi      = tag_q[1].keep_hi ? rom_q_b_i : '0;
    push_beat.lo      = rom_q_a_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      remaining_q  <= '0;
      rom_addr_a_q <= '0;
      rom_addr_b_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tag_q        <= '0;
    end else begin
      done_q   <= 1'b0;
      tag_q[1] <= tag_q[0];
      tag_q[0] <= '{valid:   issue,
                    keep_hi: issue && (remaining_q >= Two),
                    last:    issue && (remaining_q <= Two)};
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (word_count_i == '0) begin
              done_q <= 1'b1;
            end else begin
              ptr_q       <= start_addr_i;
              remaining_q <= req_len;
              busy_q      <= 1'b1;
              state_q     <= StRun;
            end
          end
        end
        StRun: begin
          if (issue) begin
            rom_addr_a_q <= ptr_q;
            rom_addr_b_q <= ptr_q + 1'b1;
            ptr_q        <= ptr_q + 2'd2;
            remaining_q  <= rem_next;
            if (rem_next == '0) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((inflight == '0) && pop && head_beat.last) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rom_stream_fifo #(
    .Width ($bits(beat_t)),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tag_q[1].valid),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (head_beat),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    busy_o       = busy_q;
    done_o       = done_q;
    rom_addr_a_o = rom_addr_a_q;
    rom_addr_b_o = rom_addr_b_q;
    m_valid_o    = ~fifo_empty;
    m_data_lo_o  = head_beat.lo;
    m_data_hi_o  = head_beat.hi;
    m_keep_hi_o  = head_beat.keep_hi;
    m_last_o     = head_beat.last;
  end

endmodule

// File: tb/tb_rom_pair_streamer.sv
// Bench for rom_pair_streamer: ROM model, queue-based beat model with a
// per-cycle compare process, directed cases and randomized commands.
module tb_rom_pair_streamer;

  localparam int unsigned DW       = 12;
  localparam int unsigned AW       = 10;
  localparam int unsigned LW       = AW + 1;
  localparam int          RomDepth = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [LW-1:0] word_count = '0;
  logic          busy, done;
  logic [AW-1:0] rom_addr_a, rom_addr_b;
  logic [DW-1:0] rom_q_a = '0;
  logic [DW-1:0] rom_q_b = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data_lo, m_data_hi;
  logic          m_keep_hi, m_last;

  logic [DW-1:0] rom [RomDepth];

  typedef struct {
    logic [DW-1:0] lo;
    logic [DW-1:0] hi;
    logic          keep;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t stall_beat;
  logic  stall_prev = 1'b0;
  logic  exp_busy = 1'b0;
  logic  exp_done = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    ready_mode = 0;

  rom_pair_streamer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .word_count_i (word_count),
    .busy_o       (busy),
    .done_o       (done),
    .rom_addr_a_o (rom_addr_a),
    .rom_addr_b_o (rom_addr_b),
    .rom_q_a_i    (rom_q_a),
    .rom_q_b_i    (rom_q_b),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_lo_o  (m_data_lo),
    .m_data_hi_o  (m_data_hi),
    .m_keep_hi_o  (m_keep_hi),
    .m_last_o     (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q_a <= rom[rom_addr_a];
    rom_q_b <= rom[rom_addr_b];
    cyc     <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: every accepted command expands into its list of expected beats.
  always @(negedge clk) begin
    beat_t b, e;
    logic  nb, nd;
    int    n;
    if (!rst_n) begin
      chk("rst_valid", m_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr_a", rom_addr_a, 0);
      chk("rst_addr_b", rom_addr_b, 0);
      exp_q.delete();
      exp_busy   = 1'b0;
      exp_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      nb = exp_busy;
      nd = 1'b0;
      b  = '{lo: m_data_lo, hi: m_data_hi, keep: m_keep_hi, last: m_last, cyc: cyc};
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_lo", b.lo, stall_beat.lo);
        chk("stall_hi", b.hi, stall_beat.hi);
        chk("stall_keep", b.keep, stall_beat.keep);
        chk("stall_last", b.last, stall_beat.last);
      end
      if (exp_q.size() == 0) chk("idle_valid", m_valid, 0);
      if (m_valid && m_ready) begin
        obs_q.push_back(b);
        if (exp_q.size() == 0) begin
          chk("extra_beat_valid", m_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_lo", b.lo, e.lo);
          chk("beat_hi", b.hi, e.hi);
          chk("beat_keep", b.keep, e.keep);
          chk("beat_last", b.last, e.last);
          if (e.last) begin
            nd = 1'b1;
            nb = 1'b0;
          end
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_beat = b;
      if (start && !exp_busy) begin
        n = (int'(word_count) > RomDepth) ? RomDepth : int'(word_count);
        if (n == 0) begin
          nd = 1'b1;
        end else begin
          nb = 1'b1;
          for (int k = 0; k < n; k += 2) begin
            e.lo   = rom[(int'(start_addr) + k) % RomDepth];
            e.keep = (k + 1 < n);
            e.hi   = e.keep ? rom[(int'(start_addr) + k + 1) % RomDepth] : '0;
            e.last = (k + 2 >= n);
            e.cyc  = 0;
            exp_q.push_back(e);
          end
        end
      end
      exp_busy = nb;
      exp_done = nd;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode != 0) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Returns one cycle after the start-sampling edge (edge + 1).
  task automatic issue_cmd(input int sa, input int wc);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = AW'(sa);
    word_count = LW'(wc);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || exp_busy || exp_done) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({name, "_timeout"}, (i < budget), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string name, input int idx, input int lo, input int hi,
                          input logic keep, input logic last);
    if (obs_q.size() <= idx) begin
      chk({name, "_present"}, obs_q.size(), idx + 1);
    end else begin
      chk({name, "_lo"}, obs_q[idx].lo, lo);
      chk({name, "_hi"}, obs_q[idx].hi, hi);
      chk({name, "_keep"}, obs_q[idx].keep, keep);
      chk({name, "_last"}, obs_q[idx].last, last);
    end
  endtask

  initial begin
    int i;
    int sa, wc;
    for (int k = 0; k < RomDepth; k++) rom[k] = DW'(k);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic run with latency and throughput pinned.
    m_ready = 1'b1;
    obs_q.delete();
    issue_cmd(0, 8);
    chk("t1_valid_e0", m_valid, 0);
    chk("t1_busy_e0", busy, 1);
    @(posedge clk); #1; chk("t1_valid_e1", m_valid, 0);
    @(posedge clk); #1; chk("t1_valid_e2", m_valid, 0);
    @(posedge clk); #1; chk("t1_valid_e3", m_valid, 1);
    chk("t1_first_lo", m_data_lo, 0);
    wait_idle("t1", 100);
    chk("t1_count", obs_q.size(), 4);
    chk_beat("t1_b0", 0, 0, 1, 1, 0);
    chk_beat("t1_b1", 1, 2, 3, 1, 0);
    chk_beat("t1_b2", 2, 4, 5, 1, 0);
    chk_beat("t1_b3", 3, 6, 7, 1, 1);
    if (obs_q.size() == 4) chk("t1_back_to_back", obs_q[3].cyc - obs_q[0].cyc, 3);

    // Odd count.
    obs_q.delete();
    issue_cmd(16, 5);
    wait_idle("t2", 100);
    chk("t2_count", obs_q.size(), 3);
    chk_beat("t2_b1", 1, 18, 19, 1, 0);
    chk_beat("t2_b2", 2, 20, 0, 0, 1);

    // Address wrap.
    obs_q.delete();
    issue_cmd(1022, 4);
    @(posedge clk); #1;
    chk("t3_addr_a0", rom_addr_a, 1022);
    chk("t3_addr_b0", rom_addr_b, 1023);
    @(posedge clk); #1;
    chk("t3_addr_a1", rom_addr_a, 0);
    chk("t3_addr_b1", rom_addr_b, 1);
    wait_idle("t3", 100);
    chk_beat("t3_b0", 0, 1022, 1023, 1, 0);
    chk_beat("t3_b1", 1, 0, 1, 1, 1);

    // Backpressure: 1,0,1,0 then ten stalled cycles.
    obs_q.delete();
    m_ready = 1'b0;
    issue_cmd(0, 16);
    i = 0;
    while (!m_valid && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    chk("t4_first_valid", m_valid, 1);
    m_ready = 1'b1; @(posedge clk); #1;
    m_ready = 1'b0; @(posedge clk); #1;
    m_ready = 1'b1; @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_frozen_a", rom_addr_a, 10);
    chk("t4_frozen_b", rom_addr_b, 11);
    m_ready = 1'b1;
    wait_idle("t4", 200);
    chk("t4_count", obs_q.size(), 8);
    chk_beat("t4_b7", 7, 14, 15, 1, 1);

    // Zero length, then a start pulsed while busy.
    obs_q.delete();
    issue_cmd(5, 0);
    chk("t5_zero_done", done, 1);
    chk("t5_zero_busy", busy, 0);
    @(posedge clk); #1;
    chk("t5_zero_done_end", done, 0);
    issue_cmd(40, 8);
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(500); word_count = LW'(6);
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t5", 100);
    chk("t5_count", obs_q.size(), 4);
    chk_beat("t5_b0", 0, 40, 41, 1, 0);

    // Reset mid-stream, then a fresh command.
    obs_q.delete();
    issue_cmd(100, 16);
    i = 0;
    while (obs_q.size() < 2 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    chk("t6_two_beats", obs_q.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", m_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_addr_a", rom_addr_a, 0);
    chk("t6_addr_b", rom_addr_b, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    obs_q.delete();
    issue_cmd(300, 6);
    wait_idle("t6", 100);
    chk("t6_count", obs_q.size(), 3);
    chk_beat("t6_b0", 0, 300, 301, 1, 0);
    chk_beat("t6_b2", 2, 304, 305, 1, 1);

    // Randomized commands over random ROM contents with random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < RomDepth; k++) rom[k] = DW'($urandom);
      sa = $urandom_range(0, RomDepth - 1);
      case (r)
        3:       wc = 0;
        7:       wc = 1500;
        9:       wc = 1024;
        default: wc = $urandom_range(1, 40);
      endcase
      issue_cmd(sa, wc);
      if ($urandom_range(0, 1) == 1) begin
        start      = 1'b1;
        start_addr = AW'($urandom);
        word_count = LW'($urandom_range(1, 20));
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_idle("rand", 5000);
    end
    ready_mode = 0;
    m_ready    = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_pair_streamer.md
Name: rom_pair_streamer

Overview:
- Upstream address sequencer and downstream stream adapter for the team's dual-port synchronous ROM (1-cycle registered read latency, no read enable).
- On a start command it drives both ROM address ports with consecutive word addresses, two words per issue.
- It captures q_a/q_b into a small FIFO and presents them as a valid/ready stream of word pairs with last/keep sideband.
- It absorbs ROM latency and downstream backpressure with no data loss or duplication.

Parameters:
- DATA_WIDTH, 12, ROM word width; must match the ROM.
- ADDR_WIDTH, 10, ROM address width; ROM depth is 2**ADDR_WIDTH.
- LEN_WIDTH, ADDR_WIDTH+1, width of word_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first word address.
- word_count  in  LEN_WIDTH  number of words to stream.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of command.
- rom_addr_a  out  ADDR_WIDTH  to ROM addr_a (even word of pair), registered.
- rom_addr_b  out  ADDR_WIDTH  to ROM addr_b (odd word of pair), registered.
- rom_q_a  in  DATA_WIDTH  from ROM q_a.
- rom_q_b  in  DATA_WIDTH  from ROM q_b.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data_lo  out  DATA_WIDTH  word at lower address of the pair.
- m_data_hi  out  DATA_WIDTH  word at higher address; zero when m_keep_hi=0.
- m_keep_hi  out  1  m_data_hi is meaningful.
- m_last  out  1  final beat of command.

Behaviour:
- Reset: clk and rst_n as above (one clock, asynchronous active-low reset). All outputs 0. FSM to IDLE, FIFO empty, pointers and counters 0. Assertion mid-command aborts it immediately; no done is produced.
- FSM IDLE:
  - start=1 with word_count≠0: latch ptr=start_addr and remaining=min(word_count, 2**ADDR_WIDTH), set busy, go to RUN.
  - start=1 with word_count=0: done pulse on the next cycle, busy stays 0, no beats.
- FSM RUN:
  - Issue rule: issue when remaining≠0 and (fifo_count + inflight − pop) < 4. inflight is 0..2 in-flight pairs; pop = m_valid & m_ready.
  - Issue action: rom_addr_a<=ptr, rom_addr_b<=ptr+1 mod 2**ADDR_WIDTH.
  - Issue tag: a 2-deep shift register carries keep_hi=(remaining≥2) and last=(remaining≤2).
  - Issue update: ptr+=2 (wraps), remaining-=min(2,remaining).
  - No issue: rom_addr_* hold their value.
  - When remaining reaches 0, go to DRAIN.
- FSM DRAIN: wait until inflight=0 and the last beat is handshaken, then go to IDLE. done=1 for one cycle and busy=0 in that same cycle, i.e. the cycle after the m_last handshake.
- ROM timing: address registered at edge t, ROM samples at t+1, and the FIFO pushes {q_b masked by keep_hi, q_a, keep_hi, last} at t+2. First m_valid is high after the 3rd rising edge following the start-sampling edge.
- Throughput: 1 beat/cycle sustained with m_ready=1.
- FIFO: 4 entries.
  - Outputs stay stable while m_valid & !m_ready.
  - Never overflows, guaranteed by the credit rule.
  - Push and pop in the same cycle are legal at any occupancy.
- Backpressure: the rule halts issue at a full credit count. Stale ROM reads are never pushed because the push is gated by the tag valid.
- Address wrap: ptr and ptr+1 wrap modulo 2**ADDR_WIDTH. A command may cross the top of the ROM.
- word_count > 2**ADDR_WIDTH saturates to 2**ADDR_WIDTH.
- start while busy: ignored, no effect.
- Odd count: the final beat has m_keep_hi=0 and m_data_hi=0. rom_addr_b is still driven with ptr+1; this is harmless.

Decomposition:
- Shared package rom_stream_pkg contains:
  - state enum {IDLE, RUN, DRAIN};
  - FIFO_DEPTH=4;
  - PIPE_LAT=2;
  - beat struct {last, keep_hi, hi, lo} parameterised by DATA_WIDTH.
- Sub-module rom_stream_fifo: 4-entry synchronous FIFO with count output and the same async active-low reset.
- The FSM, credit counter and tag pipeline stay in the top level.

Test Plan:
- Basic run: ROM rom[i]=i, start_addr=0, word_count=8, m_ready=1 -> beats (0,1),(2,3),(4,5),(6,7) on consecutive cycles. First m_valid is 3 edges after start; m_last on beat 4; done one cycle later.
- Odd count: start_addr=16, word_count=5 -> beats (16,17),(18,19),(20,0). Final beat has keep_hi=0 and m_last=1.
- Wrap: start_addr=1022, word_count=4 -> (1022,1023),(0,1). rom_addr_a goes 1022 then 0.
- Backpressure: word_count=16, m_ready pattern 1,0,1,0 then held 0 for 10 cycles then 1 -> exactly 8 beats in order, no duplicates. Data stable while stalled. rom_addr_* frozen once credits reach 4.
- Zero length and collision: word_count=0 -> no beats, done pulses the cycle after start. A second start pulsed during a busy 8-word command is ignored, giving exactly 4 beats.
- Reset: rst_n low mid-stream after beat 2 -> m_valid, busy, done and rom_addr_* are 0 immediately. A new start after release gives correct data from the new start_addr.
